// File: rtl/acs_unit.sv
// -----------------------------------------------------------------------------
// acs_unit
//   Add-compare-select stage for a K=3, rate-1/2 (7,5) Viterbi decoder.
//   Keeps four path metrics. For each accepted set of branch metrics it
//   registers the new metrics, the survivor decision per next-state and the
//   index/value of the smallest new metric.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   init        synchronous restart (reload start metrics, drop symbol)
//   in_valid    branch metrics valid this cycle
//   bm00..bm11  Hamming distance of the received pair to each codeword
//   out_valid   dec/best_state/best_pm were updated on the last edge
//   dec         survivor decision, bit n belongs to next-state n
//   best_state  index of the minimum path metric (lowest index on ties)
//   best_pm     value of the minimum path metric
//
// Handshake: in_valid is a one-cycle qualifier with no ready; every
// in_valid=1 cycle (without init) yields exactly one out_valid pulse on the
// following cycle. The consumer must accept every pulse.
// -----------------------------------------------------------------------------
module acs_unit #(
  parameter int PM_W    = 8,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init,
  input  logic            in_valid,
  input  logic [1:0]      bm00,
  input  logic [1:0]      bm01,
  input  logic [1:0]      bm10,
  input  logic [1:0]      bm11,
  output logic            out_valid,
  output logic [3:0]      dec,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] best_pm
);

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] MSB_M  = PM_W'(1) << (PM_W - 1);

  logic [3:0][PM_W-1:0] r_pm;
  logic                 r_out_valid;
  logic [3:0]           r_dec;
  logic [1:0]           r_best_state;
  logic [PM_W-1:0]      r_best_pm;

  // Candidates are one bit wider than the metrics so the add cannot wrap.
  logic [PM_W:0]        w_ca [4];
  logic [PM_W:0]        w_cb [4];
  logic [PM_W:0]        w_min [4];
  logic [3:0]           w_sel;
  logic                 w_norm;
  logic [3:0][PM_W-1:0] w_new;
  logic [1:0]           w_idx01;
  logic [1:0]           w_idx23;
  logic [PM_W-1:0]      w_val01;
  logic [PM_W-1:0]      w_val23;
  logic [1:0]           w_best_idx;
  logic [PM_W-1:0]      w_best_val;
  logic                 w_unused;

  // Trellis: ns0 <- s0/bm00 | s1/bm11, ns1 <- s2/bm10 | s3/bm01,
  //          ns2 <- s0/bm11 | s1/bm00, ns3 <- s2/bm01 | s3/bm10.
  always_comb begin
    w_ca[0] = {1'b0, r_pm[0]} + (PM_W+1)'(bm00);
    w_cb[0] = {1'b0, r_pm[1]} + (PM_W+1)'(bm11);
    w_ca[1] = {1'b0, r_pm[2]} + (PM_W+1)'(bm10);
    w_cb[1] = {1'b0, r_pm[3]} + (PM_W+1)'(bm01);
    w_ca[2] = {1'b0, r_pm[0]} + (PM_W+1)'(bm11);
    w_cb[2] = {1'b0, r_pm[1]} + (PM_W+1)'(bm00);
    w_ca[3] = {1'b0, r_pm[2]} + (PM_W+1)'(bm01);
    w_cb[3] = {1'b0, r_pm[3]} + (PM_W+1)'(bm10);
  end

  // Strict compare: a tie keeps the even predecessor (decision 0).
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < 4; i++) begin
      w_sel[i] = (w_cb[i] < w_ca[i]);
      w_min[i] = w_sel[i] ? w_cb[i] : w_ca[i];
    end
  end

  // The metric spread is small, so once every metric has its MSB set the
  // MSB carries no information and is dropped from all four at once.
  always_comb begin
    w_norm = w_min[0][PM_W-1] & w_min[1][PM_W-1] &
             w_min[2][PM_W-1] & w_min[3][PM_W-1];
    for (int i = 0; i < 4; i++) begin
      w_new[i] = w_min[i][PM_W-1:0] & ~(w_norm ? MSB_M : '0);
    end
  end

  // Bit PM_W of the winners is always 0 given the bounded spread.
  assign w_unused = w_min[0][PM_W] | w_min[1][PM_W] |
                    w_min[2][PM_W] | w_min[3][PM_W];

  // Argmin as a two-level tree; each level prefers the lower index on ties.
  always_comb begin
    w_idx01    = (w_new[1] < w_new[0]) ? 2'd1 : 2'd0;
    w_val01    = (w_new[1] < w_new[0]) ? w_new[1] : w_new[0];
    w_idx23    = (w_new[3] < w_new[2]) ? 2'd3 : 2'd2;
    w_val23    = (w_new[3] < w_new[2]) ? w_new[3] : w_new[2];
    w_best_idx = (w_val23 < w_val01) ? w_idx23 : w_idx01;
    w_best_val = (w_val23 < w_val01) ? w_val23 : w_val01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm         <= {INIT_V, INIT_V, INIT_V, PM_W'(0)};
      r_out_valid  <= 1'b0;
      r_dec        <= '0;
      r_best_state <= '0;
      r_best_pm    <= '0;
    end else if (init) begin
      r_pm         <= {INIT_V, INIT_V, INIT_V, PM_W'(0)};
      r_out_valid  <= 1'b0;
      r_dec        <= '0;
      r_best_state <= '0;
      r_best_pm    <= '0;
    end else if (in_valid) begin
      r_pm         <= w_new;
      r_out_valid  <= 1'b1;
      r_dec        <= w_sel;
      r_best_state <= w_best_idx;
      r_best_pm    <= w_best_val;
    end else begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign dec        = r_dec;
  assign best_state = r_best_state;
  assign best_pm    = r_best_pm;

endmodule

// File: tb/tb_acs_unit.sv
// -----------------------------------------------------------------------------
// tb_acs_unit
//   Directed bench for acs_unit. Drivers push the hand-computed result of each
//   symbol into exp_q; a monitor pops and compares on every out_valid.
//   Result word = {pm3, pm2, pm1, pm0, dec, best_state, best_pm}.
// -----------------------------------------------------------------------------
module tb_acs_unit;

  localparam int PM_W = 8;
  localparam int W    = 4*PM_W + 4 + 2 + PM_W;

  logic            clk;
  logic            rst_n;
  logic            init;
  logic            in_valid;
  logic [1:0]      bm00, bm01, bm10, bm11;
  logic            out_valid;
  logic [3:0]      dec;
  logic [1:0]      best_state;
  logic [PM_W-1:0] best_pm;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;
  int           n_pops;

  acs_unit #(.PM_W(PM_W), .INIT_PM(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .in_valid   (in_valid),
    .bm00       (bm00),
    .bm01       (bm01),
    .bm10       (bm10),
    .bm11       (bm11),
    .out_valid  (out_valid),
    .dec        (dec),
    .best_state (best_state),
    .best_pm    (best_pm)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input int p0, input int p1, input int p2,
                                      input int p3, input logic [3:0] d,
                                      input logic [1:0] bs, input int bp);
    mk = {PM_W'(p3), PM_W'(p2), PM_W'(p1), PM_W'(p0), d, bs, PM_W'(bp)};
  endfunction

  function automatic logic [W-1:0] actual();
    actual = {dut.r_pm[3], dut.r_pm[2], dut.r_pm[1], dut.r_pm[0],
              dec, best_state, best_pm};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] b00, input logic [1:0] b01,
                      input logic [1:0] b10, input logic [1:0] b11,
                      input logic [W-1:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    init     = 1'b0;
    bm00 = b00; bm01 = b01; bm10 = b10; bm11 = b11;
    exp_q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      init     = 1'b0;
    end
  endtask

  task automatic do_reset();
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_pops++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_out_valid: got pulse %0d expected none", n_pops);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (actual() !== e) begin
          n_errors++;
          $display("FAIL result_%0d: got %h expected %h", n_pops, actual(), e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0;
    rst_n = 1'b1; init = 1'b0; in_valid = 1'b0;
    bm00 = '0; bm01 = '0; bm10 = '0; bm11 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", actual(), mk(0, 16, 16, 16, 4'h0, 2'd0, 0));
    chk("reset_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Two symbols with bm {0,1,1,2}; ns1/ns3 tie and keep the even branch.
    send(2'd0, 2'd1, 2'd1, 2'd2, mk(0, 17, 2, 17, 4'h0, 2'd0, 0));
    send(2'd0, 2'd1, 2'd1, 2'd2, mk(0, 3, 2, 3, 4'h0, 2'd0, 0));
    idle(2);
    chk("idle_out_valid", W'(out_valid), W'(0));
    chk("idle_hold", actual(), mk(0, 3, 2, 3, 4'h0, 2'd0, 0));

    // bm00=2, bm11=0: best moves to state 2; then force every b branch to win.
    do_reset();
    send(2'd2, 2'd1, 2'd1, 2'd0, mk(2, 17, 0, 17, 4'h0, 2'd2, 0));
    send(2'd3, 2'd0, 2'd0, 2'd3, mk(5, 0, 5, 0, 4'h0, 2'd1, 0));
    send(2'd3, 2'd0, 2'd0, 2'd0, mk(0, 0, 3, 0, 4'hf, 2'd0, 0));

    // All bm = 3: metrics grow by 3 per symbol from symbol 2 on;
    // symbol 43 gives 129 -> normalized to 1, symbol 44 gives 4.
    do_reset();
    send(2'd3, 2'd3, 2'd3, 2'd3, mk(3, 19, 3, 19, 4'h0, 2'd0, 3));
    for (int k = 2; k <= 44; k++) begin
      int v;
      v = (k <= 42) ? 3*k : 3*k - 128;
      send(2'd3, 2'd3, 2'd3, 2'd3, mk(v, v, v, v, 4'h0, 2'd0, v));
    end

    // in_valid pattern 1,0,0,1 starting from all metrics = 4.
    send(2'd0, 2'd2, 2'd1, 2'd3, mk(4, 5, 4, 5, 4'hc, 2'd0, 4));
    idle(1);
    idle(1);
    chk("gap1_out_valid", W'(out_valid), W'(0));
    chk("gap1_hold", actual(), mk(4, 5, 4, 5, 4'hc, 2'd0, 4));
    send(2'd0, 2'd0, 2'd0, 2'd0, mk(4, 4, 4, 4, 4'h0, 2'd0, 4));
    chk("gap2_out_valid", W'(out_valid), W'(0));
    chk("gap2_hold", actual(), mk(4, 5, 4, 5, 4'hc, 2'd0, 4));
    idle(2);

    // init together with in_valid: symbol dropped, start metrics reloaded.
    @(negedge clk);
    init = 1'b1; in_valid = 1'b1;
    bm00 = 2'd3; bm01 = 2'd0; bm10 = 2'd0; bm11 = 2'd0;
    @(negedge clk);
    init = 1'b0; in_valid = 1'b0;
    chk("init_out_valid", W'(out_valid), W'(0));
    chk("init_state", actual(), mk(0, 16, 16, 16, 4'h0, 2'd0, 0));

    // Resume, then reset asynchronously while out_valid/dec are high.
    send(2'd2, 2'd1, 2'd1, 2'd0, mk(2, 17, 0, 17, 4'h0, 2'd2, 0));
    send(2'd3, 2'd0, 2'd0, 2'd3, mk(5, 0, 5, 0, 4'h0, 2'd1, 0));
    send(2'd3, 2'd0, 2'd0, 2'd0, mk(0, 0, 3, 0, 4'hf, 2'd0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), W'(0));
    chk("async_state", actual(), mk(0, 16, 16, 16, 4'h0, 2'd0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
